// File: rtl/async_fifo_pkg.sv
// ----------------------------------------------------------------------------
// async_fifo_pkg
// Pointer-code helpers shared by the dual-clock FIFO.
//   bin2gray / gray2bin work on a PTR_MAX_W-bit container. Callers zero-extend
//   their (ADDR_W+1)-bit pointer into the container and keep the low bits of
//   the result. Zero upper bits map to zero upper bits in both directions, so
//   one pair of functions serves every pointer width up to PTR_MAX_W.
// ----------------------------------------------------------------------------
package async_fifo_pkg;

   localparam int PTR_MAX_W = 32;

   typedef logic [PTR_MAX_W-1:0] ptr_ext_t;

   function automatic ptr_ext_t bin2gray(input ptr_ext_t bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic ptr_ext_t gray2bin(input ptr_ext_t gray);
      ptr_ext_t bin;
      bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = PTR_MAX_W-2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// ----------------------------------------------------------------------------
// gray_ptr_sync
// Two-flop synchroniser for a Gray-coded pointer entering the clk domain.
// Ports:
//   clk    in   1   destination-domain clock
//   reset  in   1   async, active-high; clears both stages to 0
//   d      in   W   Gray pointer from the source domain
//   q      out  W   synchronised Gray pointer
// ----------------------------------------------------------------------------
module gray_ptr_sync #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/async_fifo_param.sv
// ----------------------------------------------------------------------------
// async_fifo_param
// Dual-clock FIFO moving WIDTH-bit words from wr_clk to rd_clk.
// DEPTH = 1 << ADDR_W. Pointers are ADDR_W+1 bits; only their Gray forms cross
// domains. All flags and levels are registered from next-pointer values.
// Ports:
//   reset            in   1         async, active-high, clears both domains
//   wr_clk / rd_clk  in   1         write / read domain clocks
//   wr_en, wr_data   in             write request and word
//   wr_full          out  1         no free slot (wr_clk)
//   wr_almost_full   out  1         wr_level >= DEPTH-AF_MARGIN
//   wr_level         out  ADDR_W+1  stored words, write-side view
//   rd_en            in   1         read request
//   rd_data          out  WIDTH     registered read word
//   rd_valid         out  1         rd_data was popped on the last rd_clk edge
//   rd_empty         out  1         no stored word (rd_clk)
//   rd_almost_empty  out  1         rd_level <= AE_MARGIN
//   rd_level         out  ADDR_W+1  stored words, read-side view
// Build option ASYNC_FIFO_ERR_FLAGS_EN adds sticky wr_overflow (wr_clk) and
// rd_underflow (rd_clk) outputs, cleared only by reset.
// ----------------------------------------------------------------------------
module async_fifo_param
   import async_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned AF_MARGIN = 2,
   parameter int unsigned AE_MARGIN = 2
) (
   input  logic              reset,
   input  logic              wr_clk,
   input  logic              rd_clk,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   output logic              wr_full,
   output logic              wr_almost_full,
   output logic [ADDR_W:0]   wr_level,
   input  logic              rd_en,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   output logic              rd_empty,
   output logic              rd_almost_empty,
   output logic [ADDR_W:0]   rd_level
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
   ,
   output logic              wr_overflow,
   output logic              rd_underflow
`endif
);

   localparam int unsigned PW    = ADDR_W + 1;
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);
   localparam logic [PW-1:0] AE_THRESH = PW'(AE_MARGIN);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // write domain
   logic            wr_push;
   logic [PW-1:0]   wr_bin_q,   wr_bin_d;
   logic [PW-1:0]   wr_gray_q,  wr_gray_d;
   logic            wr_full_q,  wr_full_d;
   logic            wr_afull_q, wr_afull_d;
   logic [PW-1:0]   wr_level_q, wr_level_d;
   logic [PW-1:0]   rq2_gray;
   ptr_ext_t        wr_gray_ext, rq2_bin_ext;

   // read domain
   logic [1:0]       rd_rst_pipe_q, rd_rst_pipe_d;
   logic             rd_rst;
   logic             rd_pop;
   logic [PW-1:0]    rd_bin_q,    rd_bin_d;
   logic [PW-1:0]    rd_gray_q,   rd_gray_d;
   logic             rd_empty_q,  rd_empty_d;
   logic             rd_aempty_q, rd_aempty_d;
   logic [PW-1:0]    rd_level_q,  rd_level_d;
   logic             rd_valid_q,  rd_valid_d;
   logic [WIDTH-1:0] rd_data_q,   rd_data_d;
   logic [PW-1:0]    wq2_gray;
   ptr_ext_t         rd_gray_ext, wq2_bin_ext;

   // ---------------------------------------------------------------- write
   always_comb begin
      wr_push     = wr_en && !wr_full_q;
      wr_bin_d    = wr_bin_q + {{ADDR_W{1'b0}}, wr_push};
      wr_gray_ext = bin2gray(ptr_ext_t'(wr_bin_d));
      wr_gray_d   = wr_gray_ext[PW-1:0];
      rq2_bin_ext = gray2bin(ptr_ext_t'(rq2_gray));
      // Full: same slot address, opposite lap. In Gray code that means the
      // top two bits are inverted and the rest match.
      wr_full_d   = (wr_gray_d == {~rq2_gray[ADDR_W:ADDR_W-1], rq2_gray[ADDR_W-2:0]});
      wr_level_d  = wr_bin_d - rq2_bin_ext[PW-1:0];
      wr_afull_d  = (wr_level_d >= AF_THRESH);
   end

   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         wr_bin_q   <= '0;
         wr_gray_q  <= '0;
         wr_full_q  <= 1'b0;
         wr_afull_q <= 1'b0;
         wr_level_q <= '0;
      end else begin
         wr_bin_q   <= wr_bin_d;
         wr_gray_q  <= wr_gray_d;
         wr_full_q  <= wr_full_d;
         wr_afull_q <= wr_afull_d;
         wr_level_q <= wr_level_d;
      end
   end

   // Storage is intentionally left unreset.
   always_ff @(posedge wr_clk) begin
      if (wr_push) begin
         mem_q[wr_bin_q[ADDR_W-1:0]] <= wr_data;
      end
   end

   gray_ptr_sync #(.W(PW)) u_sync_r2w (
      .clk   (wr_clk),
      .reset (reset),
      .d     (rd_gray_q),
      .q     (rq2_gray)
   );

   // ----------------------------------------------------------------- read
   // Local reset: asserts with reset, releases two rd_clk edges later.
   always_comb begin
      rd_rst_pipe_d = {rd_rst_pipe_q[0], 1'b0};
   end

   always_ff @(posedge rd_clk or posedge reset) begin
      if (reset) begin
         rd_rst_pipe_q <= 2'b11;
      end else begin
         rd_rst_pipe_q <= rd_rst_pipe_d;
      end
   end

   assign rd_rst = rd_rst_pipe_q[1];

   gray_ptr_sync #(.W(PW)) u_sync_w2r (
      .clk   (rd_clk),
      .reset (rd_rst),
      .d     (wr_gray_q),
      .q     (wq2_gray)
   );

   always_comb begin
      rd_pop      = rd_en && !rd_empty_q;
      rd_bin_d    = rd_bin_q + {{ADDR_W{1'b0}}, rd_pop};
      rd_gray_ext = bin2gray(ptr_ext_t'(rd_bin_d));
      rd_gray_d   = rd_gray_ext[PW-1:0];
      wq2_bin_ext = gray2bin(ptr_ext_t'(wq2_gray));
      rd_empty_d  = (rd_gray_d == wq2_gray);
      rd_level_d  = wq2_bin_ext[PW-1:0] - rd_bin_d;
      rd_aempty_d = (rd_level_d <= AE_THRESH);
      rd_valid_d  = rd_pop;
      rd_data_d   = rd_pop ? mem_q[rd_bin_q[ADDR_W-1:0]] : rd_data_q;
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         rd_bin_q    <= '0;
         rd_gray_q   <= '0;
         rd_empty_q  <= 1'b1;
         rd_aempty_q <= 1'b1;
         rd_level_q  <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         rd_bin_q    <= rd_bin_d;
         rd_gray_q   <= rd_gray_d;
         rd_empty_q  <= rd_empty_d;
         rd_aempty_q <= rd_aempty_d;
         rd_level_q  <= rd_level_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
   logic wr_ovf_q, wr_ovf_d;
   logic rd_udf_q, rd_udf_d;

   always_comb begin
      wr_ovf_d = wr_ovf_q | (wr_en && wr_full_q);
      rd_udf_d = rd_udf_q | (rd_en && rd_empty_q);
   end

   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         wr_ovf_q <= 1'b0;
      end else begin
         wr_ovf_q <= wr_ovf_d;
      end
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         rd_udf_q <= 1'b0;
      end else begin
         rd_udf_q <= rd_udf_d;
      end
   end

   assign wr_overflow  = wr_ovf_q;
   assign rd_underflow = rd_udf_q;
`endif

   // The helpers return a full-width container; only the low PW bits matter.
   logic unused_ok;
   assign unused_ok = &{1'b0, wr_gray_ext[PTR_MAX_W-1:PW], rq2_bin_ext[PTR_MAX_W-1:PW],
                        rd_gray_ext[PTR_MAX_W-1:PW], wq2_bin_ext[PTR_MAX_W-1:PW]};

   assign wr_full         = wr_full_q;
   assign wr_almost_full  = wr_afull_q;
   assign wr_level        = wr_level_q;
   assign rd_data         = rd_data_q;
   assign rd_valid        = rd_valid_q;
   assign rd_empty        = rd_empty_q;
   assign rd_almost_empty = rd_aempty_q;
   assign rd_level        = rd_level_q;

endmodule
